// File: rtl/instruction_fetch.sv
// Instruction fetch unit: IDLE/REQUEST/WAIT/HOLD sequencer that requests one
// instruction word at a time and holds it until the decoder takes it.
// Branch redirects while a request is in flight squash the returned word.
// Optional feature: define FETCH_TIMEOUT_EN to add the fetch_fault output and
// an 8-bit WAIT timeout that parks the unit in IDLE until the next reset.
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         take,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  input  logic                         mem_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
  output logic                         mem_req,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instruction_valid,
  output logic [ADDR_WIDTH-1:0]        pc_out
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                         fetch_fault
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_WIDTH-1:0]   pc_r;
  logic                    squash_r;
  logic [ADDR_WIDTH-1:0]   pc_inc_s;
  logic                    halted_s;

  assign pc_inc_s = pc_r + ADDR_WIDTH'(1);

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_count_r;
  logic       fault_r;
  assign fetch_fault = fault_r;
  assign halted_s    = fault_r;
`else
  assign halted_s    = 1'b0;
`endif

  // Fetch sequencer: state, program counter, squash flag and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= IDLE;
      pc_r              <= RESET_VECTOR;
      squash_r          <= 1'b0;
      mem_req           <= 1'b0;
      mem_addr          <= RESET_VECTOR;
      Instruction       <= '0;
      instruction_valid <= 1'b0;
      pc_out            <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_count_r      <= 8'd0;
      fault_r           <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          // A timed-out unit stays parked here; otherwise start fetching.
          if (halted_s) begin
            state_r <= IDLE;
            mem_req <= 1'b0;
          end else if (take) begin
            pc_r     <= branch_target;
            mem_req  <= 1'b1;
            mem_addr <= branch_target;
            state_r  <= REQUEST;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= pc_r;
            state_r  <= REQUEST;
          end
        end

        REQUEST: begin
          // Memory only answers in WAIT, so a redirect here just retargets the request.
          if (take) begin
            pc_r     <= branch_target;
            mem_addr <= branch_target;
            state_r  <= REQUEST;
          end else begin
            state_r  <= WAIT;
          end
          instruction_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
          wait_count_r <= 8'd0;
`endif
        end

        WAIT: begin
          if (mem_ready) begin
            if (take || squash_r) begin
              // Returned word belongs to the abandoned path: drop it and refetch.
              squash_r          <= 1'b0;
              instruction_valid <= 1'b0;
              mem_req           <= 1'b1;
              mem_addr          <= take ? branch_target : pc_r;
              pc_r              <= take ? branch_target : pc_r;
              state_r           <= REQUEST;
            end else begin
              Instruction       <= mem_rdata;
              pc_out            <= pc_r;
              instruction_valid <= 1'b1;
              pc_r              <= pc_inc_s;
              mem_req           <= 1'b0;
              state_r           <= HOLD;
            end
          end else begin
            // Request still outstanding: remember the redirect, keep the bus stable.
            if (take) begin
              squash_r <= 1'b1;
              pc_r     <= branch_target;
            end else begin
              squash_r <= squash_r;
            end
`ifdef FETCH_TIMEOUT_EN
            wait_count_r <= wait_count_r + 8'd1;
            if (wait_count_r == 8'd254) begin
              fault_r  <= 1'b1;
              mem_req  <= 1'b0;
              squash_r <= 1'b0;
              state_r  <= IDLE;
            end else begin
              fault_r  <= fault_r;
            end
`endif
          end
        end

        HOLD: begin
          // Redirect beats consumption; otherwise wait for the decoder to accept.
          if (take) begin
            pc_r              <= branch_target;
            instruction_valid <= 1'b0;
            mem_req           <= 1'b1;
            mem_addr          <= branch_target;
            state_r           <= REQUEST;
          end else if (enable) begin
            instruction_valid <= 1'b0;
            mem_req           <= 1'b1;
            mem_addr          <= pc_r;
            state_r           <= REQUEST;
          end else begin
            state_r           <= HOLD;
          end
        end

        default: begin
          state_r <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, program address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 16, instruction word width.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, first fetch address.
REQ-004 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port enable, input, 1, downstream decode/control accepts the presented Instruction this cycle.
REQ-007 SHALL have port take, input, 1, branch redirect request.
REQ-008 SHALL have port branch_target, input, ADDR_WIDTH, redirect address, sampled when take=1.
REQ-009 SHALL have port mem_ready, input, 1, memory returns data for the outstanding request.
REQ-010 SHALL have port mem_rdata, input, INSTRUCTION_WIDTH, returned instruction word.
REQ-011 SHALL have port mem_req, output, 1, fetch request to instruction memory.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH, fetch address, stable while mem_req=1.
REQ-013 SHALL have port Instruction, output, INSTRUCTION_WIDTH, registered word feeding the decoder.
REQ-014 SHALL have port instruction_valid, output, 1, Instruction holds a live word.
REQ-015 SHALL have port pc_out, output, ADDR_WIDTH, address of the word on Instruction.

Function
REQ-016 SHALL implement FSM states IDLE, REQUEST, WAIT, HOLD; IDLE->REQUEST unconditionally after one cycle.
REQ-017 SHALL in REQUEST assert mem_req=1 with mem_addr=pc, then go to WAIT next cycle.
REQ-018 SHALL keep mem_req=1 and mem_addr unchanged in WAIT until mem_ready=1.
REQ-019 SHALL on mem_ready=1 in WAIT (not squashed): load Instruction<=mem_rdata, pc_out<=pc, instruction_valid<=1, pc<=pc+1; enter HOLD.
REQ-020 SHALL stay in HOLD with Instruction/pc_out/instruction_valid frozen while enable=0.
REQ-021 SHALL in HOLD with enable=1 treat the word as consumed, clear instruction_valid, go to REQUEST; latency mem_ready-to-instruction_valid is 1 cycle.
REQ-022 SHALL on take=1 in any non-reset state: pc<=branch_target, instruction_valid<=0, go to REQUEST, unless a request is outstanding.
REQ-023 SHALL on take=1 while in WAIT without mem_ready set a squash bit, remain in WAIT, discard the next mem_ready word, then go to REQUEST at branch_target.
REQ-024 SHALL on take=1 coincident with mem_ready=1 discard mem_rdata, leave instruction_valid=0, next mem_addr=branch_target.
REQ-025 SHALL give take priority over enable when both are 1 in HOLD.
REQ-026 SHALL ignore mem_ready outside WAIT.
REQ-027 SHALL wrap pc modulo 2^ADDR_WIDTH (all-ones +1 -> 0), no flag.

Reset
REQ-028 SHALL on reset=1 set state=IDLE, pc=RESET_VECTOR, mem_req=0, mem_addr=RESET_VECTOR, Instruction=0, instruction_valid=0, pc_out=0, squash=0, fault state cleared.
REQ-029 SHALL on reset mid-WAIT drop the outstanding request; a later mem_ready is ignored per REQ-026.

Configuration
REQ-030 SHALL, with macro FETCH_TIMEOUT_EN defined, add output fetch_fault (1 bit) and an 8-bit wait counter.
REQ-031 SHALL (FETCH_TIMEOUT_EN) clear the counter on entering WAIT; increment each WAIT cycle without mem_ready.
REQ-032 SHALL (FETCH_TIMEOUT_EN) on count reaching 255 set fetch_fault=1 (sticky until reset), deassert mem_req, enter IDLE and stay there.
REQ-033 SHALL without FETCH_TIMEOUT_EN have no fetch_fault port and wait indefinitely in WAIT.

Verification
REQ-034 SHALL cover reset release, mem_ready=1 every WAIT cycle, enable=1 -> mem_addr 0,1,2..., each word valid 1 cycle after mem_ready, pc_out matching.
REQ-035 SHALL cover enable=0 for 5 cycles with valid word 0xA5C3 -> Instruction held 0xA5C3, mem_req=0, no pc advance.
REQ-036 SHALL cover take=1, branch_target=0x40 during WAIT at 0x10 -> returned 0x10 word discarded, next mem_addr=0x40, first valid pc_out=0x40.
REQ-037 SHALL cover pc=0xFFFFFFFF fetch -> pc_out=0xFFFFFFFF, next mem_addr=0x0.
REQ-038 SHALL cover (FETCH_TIMEOUT_EN) mem_ready held 0 for 255 WAIT cycles -> fetch_fault=1, mem_req=0; reset clears it.
